e_rr_arb: RTL and testbench

Round-robin arbiter that shares one downstream resource among `N` requesters with a registered valid/accept grant handshake.
- Priority state is a thermometer mask, in complement unary form, of the requesters above the last accepted winner.
- A bounded lock mode lets a winner hold the resource across consecutive transfers.
- An instance of the unary admission checker `e` continuously validates the mask; this catches state corruption in the scheduler.

---
 rtl/e_pkg.sv | 17 +
 rtl/e.sv | 23 ++
 rtl/e_rr_arb.sv | 152 +++++++++++++++
 tb/tb_e_rr_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/e_pkg.sv
// Shared types and helpers for the round-robin arbiter and its mask checker.
package e_pkg;

  localparam int unsigned E_MAX_N = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OFFER  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  // Ones strictly above bit k; k = width-1 (or beyond) yields all-zero.
  function automatic logic [E_MAX_N-1:0] mask_above(input int unsigned k);
    mask_above = {E_MAX_N{1'b1}} << (k + 1);
  endfunction

endpackage

// File: rtl/e.sv
// Unary admission checker: accepts low-aligned thermometer codes and,
// when enabled, their complement (high-aligned runs of ones).
module e #(
  parameter int W                     = 4,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b0
) (
  input  logic [W-1:0] i_data,
  output logic         o_is_unary
);

  logic [W-1:0] inv;
  logic         lo_unary;
  logic         hi_unary;

  assign inv = ~i_data;

  // A value is a low-aligned run of ones iff adding one clears every set bit.
  assign lo_unary = ((i_data & (i_data + W'(1))) == '0);
  assign hi_unary = ((inv & (inv + W'(1))) == '0);

  assign o_is_unary = lo_unary | (P_ADMIT_COMPLIMENT_EN & hi_unary);

endmodule

// File: rtl/e_rr_arb.sv
// Round-robin arbiter with registered grant, valid/accept handshake, bounded
// lock mode, and a continuously checked thermometer priority mask.
//
// state      | meaning
// ARB_IDLE   | no offer
// ARB_OFFER  | grant valid, awaiting accept
// ARB_LOCKED | grant valid, winner holding the resource
module e_rr_arb
  import e_pkg::*;
#(
  parameter int N          = 4,
  parameter int P_LOCK_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         i_req,
  input  logic                 i_lock,
  input  logic                 i_accept,
  output logic                 o_gnt_vld,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx,
  output logic                 o_mask_err
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(P_LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(P_LOCK_MAX);

  arb_state_e    state, state_n;
  logic [IW-1:0] gnt_idx, idx_n;
  logic [N-1:0]  mask, mask_n;
  logic [CW-1:0] lock_cnt, cnt_n;
  logic          mask_err;
  logic          mask_ok;

  logic [N-1:0]  m_acc;
  logic [IW-1:0] pick_cur;
  logic [IW-1:0] pick_acc;
  logic          any_req;

  // Lowest requester inside the mask, falling back to the lowest overall.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] req,
                                         input logic [N-1:0] m);
    logic [N-1:0] c;
    logic [N-1:0] src;
    c    = req & m;
    src  = (c != '0) ? c : req;
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) pick = IW'(i);
    end
  endfunction

  assign m_acc    = N'(mask_above(32'(gnt_idx)));
  assign pick_cur = pick(i_req, mask);
  assign pick_acc = pick(i_req, m_acc);
  assign any_req  = |i_req;

  always_comb begin
    state_n = state;
    idx_n   = gnt_idx;
    mask_n  = mask;
    cnt_n   = lock_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_n = ARB_OFFER;
          idx_n   = pick_cur;
        end
      end
      ARB_OFFER: begin
        if (i_accept) begin
          mask_n = m_acc;
          if (i_lock) begin
            state_n = ARB_LOCKED;
            cnt_n   = CW'(1);
          end else if (any_req) begin
            idx_n = pick_acc;
          end else begin
            state_n = ARB_IDLE;
            idx_n   = '0;
          end
        end else if (!i_req[gnt_idx]) begin
          // Withdrawn offer: re-pick against the unchanged mask.
          if (any_req) begin
            idx_n = pick_cur;
          end else begin
            state_n = ARB_IDLE;
            idx_n   = '0;
          end
        end
      end
      ARB_LOCKED: begin
        if (i_accept) begin
          if (!i_lock || lock_cnt == LOCK_MAX) begin
            mask_n = m_acc;
            cnt_n  = '0;
            if (any_req) begin
              state_n = ARB_OFFER;
              idx_n   = pick_acc;
            end else begin
              state_n = ARB_IDLE;
              idx_n   = '0;
            end
          end else begin
            cnt_n = lock_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = ARB_IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      gnt_idx  <= '0;
      mask     <= '1;
      lock_cnt <= '0;
      mask_err <= 1'b0;
    end else begin
      state    <= state_n;
      gnt_idx  <= idx_n;
      mask     <= mask_n;
      lock_cnt <= cnt_n;
      mask_err <= !mask_ok;
    end
  end

  e #(
    .W                    (N),
    .P_ADMIT_COMPLIMENT_EN(1'b1)
  ) u_mask_chk (
    .i_data    (mask),
    .o_is_unary(mask_ok)
  );

  // Outputs decode only registered state.
  always_comb begin
    o_gnt = '0;
    if (state != ARB_IDLE) o_gnt[gnt_idx] = 1'b1;
  end

  assign o_gnt_vld  = (state != ARB_IDLE);
  assign o_gnt_idx  = gnt_idx;
  assign o_mask_err = mask_err;

endmodule

// File: tb/tb_e_rr_arb.sv
// Bench for e_rr_arb: pointer-based rotation model checked every cycle,
// directed scenarios with literal expectations, then a random soak.
module tb_e_rr_arb;

  localparam int N  = 4;
  localparam int PL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_req = '0;
  logic       i_lock = 1'b0;
  logic       i_accept = 1'b0;
  logic       o_gnt_vld;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_idx;
  logic       o_mask_err;

  int checks = 0;
  int failures = 0;

  // Model: last accepted index (-1 = none), busy, current winner, lock holds.
  int m_last = -1;
  bit m_busy = 1'b0;
  int m_win = 0;
  int m_cnt = 0;

  int wait_cnt[N];

  e_rr_arb #(.N(N), .P_LOCK_MAX(PL)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_lock    (i_lock),
    .i_accept  (i_accept),
    .o_gnt_vld (o_gnt_vld),
    .o_gnt     (o_gnt),
    .o_gnt_idx (o_gnt_idx),
    .o_mask_err(o_mask_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next requester after 'last' in circular order.
  function automatic int choose(input logic [3:0] req, input int last);
    for (int i = last + 1; i < N; i++) if (req[i]) return i;
    for (int i = 0; i < N; i++) if (req[i]) return i;
    return 0;
  endfunction

  task automatic rearb(input logic [3:0] req);
    if (req == '0) begin
      m_busy = 1'b0;
      m_win  = 0;
    end else begin
      m_win = choose(req, m_last);
    end
  endtask

  task automatic model_step(input bit r, input logic [3:0] req, input bit acc, input bit lk);
    if (r) begin
      m_busy = 1'b0; m_win = 0; m_last = -1; m_cnt = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_busy = 1'b1;
        m_win  = choose(req, m_last);
      end
    end else if (m_cnt > 0) begin
      if (acc) begin
        if (!lk || m_cnt == PL) begin
          m_last = m_win; m_cnt = 0;
          rearb(req);
        end else begin
          m_cnt++;
        end
      end
    end else if (acc) begin
      m_last = m_win;
      if (lk) m_cnt = 1;
      else rearb(req);
    end else if (!req[m_win]) begin
      rearb(req);
    end
  endtask

  task automatic compare_model();
    logic [3:0] eg;
    eg = m_busy ? 4'(1 << m_win) : 4'b0000;
    chk("gnt_vld", 32'(o_gnt_vld), 32'(m_busy));
    chk("gnt", 32'(o_gnt), 32'(eg));
    chk("gnt_idx", 32'(o_gnt_idx), m_busy ? 32'(m_win) : 32'd0);
    chk("mask_err", 32'(o_mask_err), 32'd0);
  endtask

  task automatic cyc(input logic [3:0] req, input bit acc, input bit lk);
    i_req = req; i_accept = acc; i_lock = lk;
    @(posedge clk);
    model_step(rst, req, acc, lk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    logic [3:0] rq;
    bit ac, lk;
    int mx;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    do_reset();
    chk("rst_vld", 32'(o_gnt_vld), 32'd0);
    chk("rst_gnt", 32'(o_gnt), 32'd0);

    // Full rotation with continuous accepts
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      chk("rr_gnt", 32'(o_gnt), 32'(rr_exp[i]));
      chk("rr_vld", 32'(o_gnt_vld), 32'd1);
    end

    // Hold while unaccepted, then accept with simultaneous drop
    do_reset();
    cyc(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0100, 1'b0, 1'b0);
      chk("hold_gnt", 32'(o_gnt), 32'h4);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    chk("acc_idle_vld", 32'(o_gnt_vld), 32'd0);
    chk("acc_idle_idx", 32'(o_gnt_idx), 32'd0);
    cyc(4'b1111, 1'b0, 1'b0);
    chk("after2_gnt", 32'(o_gnt), 32'h8);

    // Lock with forced release after PL locked accepts
    do_reset();
    cyc(4'b0011, 1'b1, 1'b1);
    chk("lk_offer", 32'(o_gnt), 32'h1);
    cyc(4'b0011, 1'b1, 1'b1);
    chk("lk_enter", 32'(o_gnt), 32'h1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("lk_noreq_vld", 32'(o_gnt_vld), 32'd1);
    chk("lk_noreq_gnt", 32'(o_gnt), 32'h1);
    cyc(4'b0011, 1'b1, 1'b1);
    chk("lk_hold2", 32'(o_gnt), 32'h1);
    cyc(4'b0011, 1'b1, 1'b1);
    chk("lk_hold3", 32'(o_gnt), 32'h1);
    cyc(4'b0011, 1'b1, 1'b1);
    chk("lk_release", 32'(o_gnt), 32'h2);

    // Withdraw before accept leaves mask untouched
    do_reset();
    cyc(4'b0010, 1'b0, 1'b0);
    chk("wd_gnt", 32'(o_gnt), 32'h2);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("wd_vld", 32'(o_gnt_vld), 32'd0);
    cyc(4'b1111, 1'b0, 1'b0);
    chk("wd_regnt", 32'(o_gnt), 32'h1);

    // Reset while locked
    cyc(4'b1111, 1'b1, 1'b1);
    rst = 1'b1;
    cyc(4'b1111, 1'b1, 1'b1);
    rst = 1'b0;
    chk("rstlk_vld", 32'(o_gnt_vld), 32'd0);
    chk("rstlk_gnt", 32'(o_gnt), 32'd0);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("rstlk_g3", 32'(o_gnt), 32'h8);
    chk("rstlk_i3", 32'(o_gnt_idx), 32'd3);

    // Random soak with fairness bound
    do_reset();
    for (int j = 0; j < N; j++) wait_cnt[j] = 0;
    for (int c = 0; c < 10000; c++) begin
      rq = 4'($urandom_range(0, 15));
      ac = 1'($urandom_range(0, 1));
      lk = ($urandom_range(0, 3) == 0);
      i_req = rq; i_accept = ac;
      mx = 0;
      for (int j = 0; j < N; j++) begin
        if (!rq[j] || (o_gnt_vld && o_gnt_idx == 2'(j))) wait_cnt[j] = 0;
        else if (o_gnt_vld && ac && m_cnt == 0) wait_cnt[j]++;
        if (wait_cnt[j] > mx) mx = wait_cnt[j];
      end
      chk("fair_wait_le_n", 32'(mx <= N), 32'd1);
      cyc(rq, ac, lk);
      chk("onehot0", 32'($onehot0(o_gnt)), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
